// File: rtl/conv_result_accumulator.sv
// conv_result_accumulator
//   Collects per-channel F x F window results from the multiplier array and sums
//   them across K input channels into an OUT_SIZE x OUT_SIZE output-map buffer.
//   Progress is reported back to the convolution controller, and the finished map
//   is read out through a 1-cycle-latency read port.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             pulse: clear the buffer and begin a new map (any state)
//   batch_start       pulse: register batch_len as the new outstanding batch
//   batch_len         number of beats expected in the batch
//   in_valid/in_ready result beat handshake (in_ready high only while collecting)
//   in_data           signed multiplier result
//   in_pos, in_ch     output position (row*OUT_SIZE+col) and input channel
//   conv_done_partial 1-cycle pulse when the outstanding batch has fully returned
//   conv_done_full    level once OUT_SIZE*OUT_SIZE*K in-range beats were accepted
//   rd_en, rd_addr    read request and position
//   rd_data           accumulated value, valid one cycle after rd_en, else holds
//   err               sticky: bad index, batch overrun/underrun or saturation
module conv_result_accumulator #(
    parameter int W        = 24,
    parameter int ACCW     = 32,
    parameter int OUT_SIZE = 30,
    parameter int K        = 3,
    parameter int PW       = 10,
    parameter int KW       = 2,
    parameter int BW       = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            batch_start,
    input  logic [BW-1:0]   batch_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [PW-1:0]   in_pos,
    input  logic [KW-1:0]   in_ch,
    output logic            conv_done_partial,
    output logic            conv_done_full,
    input  logic            rd_en,
    input  logic [PW-1:0]   rd_addr,
    output logic [ACCW-1:0] rd_data,
    output logic            err
);

    localparam int NPOS = OUT_SIZE * OUT_SIZE;
    localparam int AW   = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam int TW   = PW + KW + 1;

    // One extra bit so that NPOS == 2^PW and K == 2^KW still fit.
    localparam logic [PW:0]   NPOS_P     = (PW + 1)'(NPOS);
    localparam logic [KW:0]   K_P        = (KW + 1)'(K);
    localparam logic [PW-1:0] CLR_LAST   = PW'(NPOS - 1);
    localparam logic [TW-1:0] TOTAL_LAST = TW'(NPOS * K - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Saturating add of a sign-extended result onto an accumulator entry.
    // Returns {clamped, value}.
    function automatic logic [ACCW:0] sat_add(input logic [ACCW-1:0] acc,
                                              input logic [W-1:0]    din);
        logic signed [ACCW:0] a_ext;
        logic signed [ACCW:0] d_ext;
        logic signed [ACCW:0] sum;
        logic        [ACCW:0] res;
        a_ext = $signed({acc[ACCW-1], acc});
        d_ext = $signed({{(ACCW + 1 - W){din[W-1]}}, din});
        sum   = a_ext + d_ext;
        if (sum[ACCW] != sum[ACCW-1]) begin
            if (sum[ACCW]) begin
                res = {1'b1, 1'b1, {(ACCW - 1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(ACCW - 1){1'b1}}};
            end
        end else begin
            res = {1'b0, sum[ACCW-1:0]};
        end
        return res;
    endfunction

    state_t          state_r;
    logic [PW-1:0]   clr_cnt_r;
    logic [TW-1:0]   total_cnt_r;
    logic [BW-1:0]   batch_rem_r;
    logic            in_ready_r;
    logic            partial_r;
    logic            done_full_r;
    logic            err_r;
    logic [ACCW-1:0] rd_data_r;
    logic [ACCW-1:0] mem_r [0:NPOS-1];

    logic            accept_s;
    logic            idx_ok_s;
    logic            rd_ok_s;
    logic [ACCW:0]   sat_res_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_addr_s;
    logic [ACCW-1:0] wr_data_s;

    // start always wins, so a beat arriving with start is dropped.
    assign accept_s  = in_valid && (state_r == COLLECT) && !start;
    assign idx_ok_s  = ({1'b0, in_pos} < NPOS_P) && ({1'b0, in_ch} < K_P);
    assign rd_ok_s   = ({1'b0, rd_addr} < NPOS_P);
    // Read-modify-write happens in one cycle, so a following beat to the same
    // position sees the updated entry.
    assign sat_res_s = sat_add(mem_r[AW'(in_pos)], in_data);

    // Buffer write-port mux: sequential clearing or accumulation.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {ACCW{1'b0}};
        if ((state_r == CLEAR) && !start) begin
            wr_en_s   = 1'b1;
            wr_addr_s = AW'(clr_cnt_r);
        end else if (accept_s && idx_ok_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = AW'(in_pos);
            wr_data_s = sat_res_s[ACCW-1:0];
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Output-map buffer storage (contents undefined until cleared).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Control FSM, beat/batch counters and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            clr_cnt_r   <= {PW{1'b0}};
            total_cnt_r <= {TW{1'b0}};
            batch_rem_r <= {BW{1'b0}};
            in_ready_r  <= 1'b0;
            partial_r   <= 1'b0;
            done_full_r <= 1'b0;
            err_r       <= 1'b0;
        end else if (start) begin
            state_r     <= CLEAR;
            clr_cnt_r   <= {PW{1'b0}};
            total_cnt_r <= {TW{1'b0}};
            batch_rem_r <= {BW{1'b0}};
            in_ready_r  <= 1'b0;
            partial_r   <= 1'b0;
            done_full_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            partial_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                CLEAR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r    <= COLLECT;
                        in_ready_r <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + PW'(1);
                    end
                end
                COLLECT: begin
                    // Batch tracking: a beat in the same cycle as batch_start
                    // belongs to the new batch.
                    if (batch_start) begin
                        if (batch_rem_r != {BW{1'b0}}) begin
                            err_r <= 1'b1;
                        end
                        if (accept_s) begin
                            if (batch_len == {BW{1'b0}}) begin
                                batch_rem_r <= {BW{1'b0}};
                                err_r       <= 1'b1;
                            end else begin
                                batch_rem_r <= batch_len - BW'(1);
                                if (batch_len == BW'(1)) begin
                                    partial_r <= 1'b1;
                                end
                            end
                        end else begin
                            batch_rem_r <= batch_len;
                        end
                    end else if (accept_s) begin
                        if (batch_rem_r == {BW{1'b0}}) begin
                            err_r <= 1'b1;
                        end else begin
                            batch_rem_r <= batch_rem_r - BW'(1);
                            if (batch_rem_r == BW'(1)) begin
                                partial_r <= 1'b1;
                            end
                        end
                    end else begin
                        batch_rem_r <= batch_rem_r;
                    end

                    // Map completion: only in-range beats count.
                    if (accept_s) begin
                        if (!idx_ok_s) begin
                            err_r <= 1'b1;
                        end else begin
                            if (sat_res_s[ACCW]) begin
                                err_r <= 1'b1;
                            end
                            total_cnt_r <= total_cnt_r + TW'(1);
                            if (total_cnt_r == TOTAL_LAST) begin
                                state_r     <= DONE;
                                in_ready_r  <= 1'b0;
                                done_full_r <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_full_r <= 1'b1;
                    in_ready_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Read port: returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {ACCW{1'b0}};
        end else if (rd_en) begin
            if (rd_ok_s) begin
                rd_data_r <= mem_r[AW'(rd_addr)];
            end else begin
                rd_data_r <= {ACCW{1'b0}};
            end
        end
    end

    assign in_ready          = in_ready_r;
    assign conv_done_partial = partial_r;
    assign conv_done_full    = done_full_r;
    assign rd_data           = rd_data_r;
    assign err               = err_r;

endmodule

// File: tb/tb_conv_result_accumulator.sv
// Self-checking bench for conv_result_accumulator with OUT_SIZE=2, K=2, W=8,
// ACCW=10. A small reference model of the output map predicts every read; read
// expectations go into a scoreboard queue when the read is issued and are popped
// against captured rd_data values.
module tb_conv_result_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       batch_start;
    logic [3:0] batch_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_pos;
    logic [0:0] in_ch;
    logic       conv_done_partial;
    logic       conv_done_full;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [9:0] rd_data;
    logic       err;

    int model [0:3];
    int exp_q [$];
    int obs_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    conv_result_accumulator #(
        .W(8), .ACCW(10), .OUT_SIZE(2), .K(2), .PW(3), .KW(1), .BW(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .batch_start(batch_start), .batch_len(batch_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_pos(in_pos), .in_ch(in_ch),
        .conv_done_partial(conv_done_partial), .conv_done_full(conv_done_full),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int sat10(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    // One beat; partial/full sampled in the cycle after the accepting edge.
    task automatic send_beat(input int pos, input int ch, input int data,
                             input logic bs, input int blen,
                             output logic p, output logic f);
        in_valid = 1'b1;
        in_pos = pos[2:0];
        in_ch = ch[0:0];
        in_data = data[7:0];
        batch_start = bs;
        batch_len = blen[3:0];
        if (pos < 4 && ch < 2) model[pos] = sat10(model[pos] + data);
        @(posedge clk); #1;
        p = conv_done_partial;
        f = conv_done_full;
        in_valid = 1'b0;
        batch_start = 1'b0;
    endtask

    task automatic do_batch(input int len);
        batch_start = 1'b1;
        batch_len = len[3:0];
        @(posedge clk); #1;
        batch_start = 1'b0;
    endtask

    task automatic read_map(input int n);
        int got;
        for (int a = 0; a < n; a++) begin
            rd_en = 1'b1;
            rd_addr = a[2:0];
            exp_q.push_back((a < 4) ? model[a] : 0);
            @(posedge clk); #1;
            got = $signed(rd_data);
            obs_q.push_back(got);
        end
        rd_en = 1'b0;
    endtask

    task automatic do_start();
        int cycles;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        cycles = 0;
        while (!in_ready && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        n_checks++;
        if (cycles !== 4) $display("FAIL clear_len got %0d cycles exp 4", cycles);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; batch_start = 1'b0; batch_len = 4'd0;
        in_valid = 1'b0; in_data = 8'd0; in_pos = 3'd0; in_ch = 1'b0;
        rd_en = 1'b0; rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (conv_done_partial !== 1'b0) $display("FAIL rst_partial got %b exp 0", conv_done_partial); else n_pass++;
        n_checks++; if (conv_done_full !== 1'b0) $display("FAIL rst_full got %b exp 0", conv_done_full); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
        n_checks++; if (rd_data !== 10'd0) $display("FAIL rst_rd got %0d exp 0", rd_data); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic p, f;
        int e, g;
        do_start();
        do_batch(8);
        for (int i = 0; i < 4; i++) begin
            send_beat(i, 0, i + 1, 1'b0, 0, p, f);
            n_checks++; if ({p, f} !== 2'b00) $display("FAIL basic_pf beat %0d got %b%b exp 00", i, p, f); else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            send_beat(i, 1, 10, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 3) ? 2'b11 : 2'b00)) $display("FAIL basic_pf beat %0d got %b%b", i + 4, p, f);
            else n_pass++;
        end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL basic_ready_done got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL basic_err got %b exp 0", err); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({conv_done_partial, conv_done_full} !== 2'b01)
            $display("FAIL basic_after got %b%b exp 01", conv_done_partial, conv_done_full);
        else n_pass++;
        read_map(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL basic_rd got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    task automatic test_split();
        logic p, f;
        int e, g;
        do_start();
        do_batch(3);
        for (int i = 0; i < 3; i++) begin
            send_beat(i, 0, i + 5, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 2) ? 2'b10 : 2'b00)) $display("FAIL split_pf1 beat %0d got %b%b", i, p, f);
            else n_pass++;
        end
        // New batch of 5 started together with its first beat.
        send_beat(3, 0, -3, 1'b1, 5, p, f);
        n_checks++; if ({p, f} !== 2'b00) $display("FAIL split_pf_bs got %b%b exp 00", p, f); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            send_beat(i, 1, 2 * i, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 3) ? 2'b11 : 2'b00)) $display("FAIL split_pf2 beat %0d got %b%b", i, p, f);
            else n_pass++;
        end
        n_checks++; if (err !== 1'b0) $display("FAIL split_err got %b exp 0", err); else n_pass++;
        read_map(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL split_rd got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic p, f;
        int e, g;
        do_start();
        do_batch(8);
        send_beat(0, 0, 127, 1'b0, 0, p, f);
        // Read of pos0 colliding with a write to pos0 returns the old value.
        rd_en = 1'b1; rd_addr = 3'd0;
        exp_q.push_back(model[0]);
        send_beat(0, 1, 127, 1'b0, 0, p, f);
        rd_en = 1'b0;
        g = $signed(rd_data);
        obs_q.push_back(g);
        for (int i = 0; i < 3; i++) begin
            send_beat(0, 0, 127, 1'b0, 0, p, f);
            n_checks++;
            if (err !== ((i == 2) ? 1'b1 : 1'b0)) $display("FAIL sat_err beat %0d got %b", i + 2, err);
            else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            send_beat(i, 1, -128, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 3) ? 2'b11 : 2'b00)) $display("FAIL sat_pf beat %0d got %b%b", i, p, f);
            else n_pass++;
        end
        read_map(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL sat_rd got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    task automatic test_bad_index();
        logic p, f;
        int e, g;
        do_start();
        n_checks++; if (err !== 1'b0) $display("FAIL bad_err_cleared got %b exp 0", err); else n_pass++;
        do_batch(9);
        send_beat(5, 0, 7, 1'b0, 0, p, f);
        n_checks++; if ({p, f, err} !== 3'b001) $display("FAIL bad_first got %b%b%b exp 001", p, f, err); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            send_beat(i % 4, i / 4, i + 1, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 7) ? 2'b11 : 2'b00)) $display("FAIL bad_pf beat %0d got %b%b", i, p, f);
            else n_pass++;
        end
        read_map(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL bad_rd got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    task automatic test_overrun();
        logic p, f;
        int e, g;
        do_start();
        do_batch(4);
        send_beat(0, 0, 1, 1'b0, 0, p, f);
        send_beat(1, 0, 1, 1'b0, 0, p, f);
        do_batch(6);
        n_checks++; if ({conv_done_partial, err} !== 2'b01) $display("FAIL ovr_err got %b%b exp 01", conv_done_partial, err); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            send_beat((i + 2) % 4, (i + 2) / 4, 20, 1'b0, 0, p, f);
            n_checks++;
            if ({p, f} !== ((i == 5) ? 2'b11 : 2'b00)) $display("FAIL ovr_pf beat %0d got %b%b", i, p, f);
            else n_pass++;
        end
        read_map(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL ovr_rd got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    task automatic test_reset_restart();
        logic p, f;
        int e, g;
        do_start();
        do_batch(8);
        for (int i = 0; i < 3; i++) send_beat(i, 0, 9, 1'b0, 0, p, f);
        send_beat(6, 0, 9, 1'b0, 0, p, f);
        rst = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, conv_done_partial, conv_done_full, err} !== 4'b0000)
            $display("FAIL rr_outputs got %b%b%b%b exp 0000", in_ready, conv_done_partial, conv_done_full, err);
        else n_pass++;
        n_checks++; if (rd_data !== 10'd0) $display("FAIL rr_rd got %0d exp 0", rd_data); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rr_idle got %b exp 0", in_ready); else n_pass++;
        do_start();
        n_checks++; if (err !== 1'b0) $display("FAIL rr_err got %b exp 0", err); else n_pass++;
        read_map(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL rr_rd_clear got %0d exp %0d", g, e); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_saturation();
        test_bad_index();
        test_overrun();
        test_reset_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
